// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//   rf_state_e : sequencer states (INIT sweeps storage, RUN serves ports)
//   port_addr  : pulls port N's address out of a flattened address bus
//   port_data  : pulls port N's data out of a flattened data bus
// Flattened buses are zero-extended to MAX_BUS_W by the caller and the
// returned slice is truncated back to the real width at the call site.
package regfile_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;

  localparam int MAX_BUS_W  = 1024;
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_DATA_W = 128;

  function automatic logic [MAX_ADDR_W-1:0] port_addr(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   port,
    input int                   addr_w
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << addr_w) - MAX_ADDR_W'(1);
    return MAX_ADDR_W'(bus >> (port * addr_w)) & mask;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] port_data(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   port,
    input int                   data_w
  );
    logic [MAX_DATA_W-1:0] mask;
    mask = (MAX_DATA_W'(1) << data_w) - MAX_DATA_W'(1);
    return MAX_DATA_W'(bus >> (port * data_w)) & mask;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Port bundle for multiport_register_file.
//   raddr/rdata/rbusy       : NUM_RD read ports (flattened, port i at slice i)
//   wen/waddr/wdata         : NUM_WR write ports, higher index wins conflicts
//   issue_valid/issue_rd    : destination-register issue for the scoreboard
//   clr_req                 : re-initialisation request
//   ready                   : high while the file serves its ports
// master = the pipeline driving the file, slave = the register file.
interface multiport_register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [NUM_WR-1:0]        wen;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_rd;
  logic                     clr_req;
  logic                     ready;

  modport master (
    output raddr, wen, waddr, wdata, issue_valid, issue_rd, clr_req,
    input  rdata, rbusy, ready
  );

  modport slave (
    input  raddr, wen, waddr, wdata, issue_valid, issue_rd, clr_req,
    output rdata, rbusy, ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Resolves NUM_WR write ports into one enable/data pair per entry.
//   wen/waddr/wdata : raw write ports (already gated by the caller)
//   we[a], wd[a]    : entry a is written this cycle with wd[a]
// Ports are scanned low to high so the highest-index enabled port targeting
// an address leaves its data last. Storage and read bypass both consume this
// single result, so they can never disagree on who won a conflict.
module rf_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_WR = 2,
  localparam int DEPTH = 2**ADDR_W
) (
  input  logic [NUM_WR-1:0]             wen,
  input  logic [NUM_WR*ADDR_W-1:0]      waddr,
  input  logic [NUM_WR*DATA_W-1:0]      wdata,
  output logic [DEPTH-1:0]              we,
  output logic [DEPTH-1:0][DATA_W-1:0]  wd
);

  logic [NUM_WR-1:0][ADDR_W-1:0] wa;
  logic [NUM_WR-1:0][DATA_W-1:0] wdt;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_port
    assign wa[p]  = ADDR_W'(port_addr(MAX_BUS_W'(waddr), p, ADDR_W));
    assign wdt[p] = DATA_W'(port_data(MAX_BUS_W'(wdata), p, DATA_W));
  end

  always_comb begin
    we = '0;
    wd = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wen[p]) begin
        we[wa[p]] = 1'b1;
        wd[wa[p]] = wdt[p];
      end
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-read / multi-write register file with hardwired-zero entry 0,
// write-to-read bypass, per-entry busy scoreboard and an init sequencer.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : multiport_register_file_if slave (read/write/issue/clr/ready)
// After reset or clr_req the sequencer zeroes one entry per cycle for DEPTH
// cycles, loads PRESET_VAL into PRESET_IDX on the last sweep cycle, then
// enters RUN. Ports are only honoured in RUN.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter int                NUM_RD     = 2,
  parameter int                NUM_WR     = 2,
  parameter int                PRESET_IDX = 9,
  parameter logic [DATA_W-1:0] PRESET_VAL = 100
) (
  input  logic                        clk,
  input  logic                        reset,
  multiport_register_file_if.slave    bus
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);
  localparam logic [ADDR_W-1:0] PIDX  = ADDR_W'(PRESET_IDX);

  rf_state_e                    state, state_nxt;
  logic [ADDR_W-1:0]            idx, idx_nxt;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic [DATA_W-1:0]            mem [DEPTH];

  logic                         ready;
  logic                         init_last;
  logic [NUM_WR-1:0]            wen_g;
  logic [DEPTH-1:0]             we;
  logic [DEPTH-1:0][DATA_W-1:0] wd;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_arr;
  logic [NUM_RD-1:0]            rb_arr;

  assign ready     = (state == RUN);
  assign init_last = (state == INIT) && (idx == LAST);
  // Writes during INIT are dropped here, so neither storage, bypass nor the
  // scoreboard clear ever see them.
  assign wen_g     = bus.wen & {NUM_WR{ready}};

  rf_write_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_arb (
    .wen   (wen_g),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .we    (we),
    .wd    (wd)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
      idx   <= '0;
      busy  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      busy  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy_nxt  = busy;
    case (state)
      INIT: begin
        idx_nxt = idx + 1'b1;
        if (init_last) state_nxt = RUN;
      end
      RUN: begin
        // Issue beats write-clear on the same entry: the new producer owns it.
        for (int a = 1; a < DEPTH; a++) begin
          if (bus.issue_valid && (bus.issue_rd == ADDR_W'(a)))
            busy_nxt[a] = 1'b1;
          else if (we[a])
            busy_nxt[a] = 1'b0;
        end
        if (bus.clr_req) begin
          state_nxt = INIT;
          idx_nxt   = '0;
          busy_nxt  = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // ------------------------------------------------------------ storage
  // A clr_req cycle is still RUN here, so its writes land and are then
  // swept away by INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == INIT) begin
        mem[idx] <= '0;
        // Placed after the sweep write so the preset survives even when it
        // targets the last entry.
        if (init_last && (PRESET_IDX != 0)) mem[PIDX] <= PRESET_VAL;
      end else begin
        for (int a = 1; a < DEPTH; a++) begin
          if (we[a]) mem[a] <= wd[a];
        end
      end
    end
  end

  // --------------------------------------------------------- read ports
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              live;
    assign ra   = ADDR_W'(port_addr(MAX_BUS_W'(bus.raddr), i, ADDR_W));
    assign live = ready && (ra != '0);
    assign rd_arr[i] = !live  ? '0     :
                       we[ra] ? wd[ra] : mem[ra];
    // A same-cycle write means the value is already here; no stall needed.
    assign rb_arr[i] = live && busy[ra] && !we[ra];
  end

  assign bus.rdata = rd_arr;
  assign bus.rbusy = rb_arr;
  assign bus.ready = ready;

endmodule

// File: tb/tb_multiport_register_file.sv
module tb_multiport_register_file;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  // observation points for the scoreboard
  localparam int K_RD0 = 0;
  localparam int K_RD1 = 1;
  localparam int K_RB0 = 2;
  localparam int K_RB1 = 3;
  localparam int K_RDY = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multiport_register_file_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  multiport_register_file #(
    .DATA_W (DW), .ADDR_W (AW), .NUM_RD (NR), .NUM_WR (NW),
    .PRESET_IDX (9), .PRESET_VAL (32'd100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic push(input int kind, input string tag, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_RD0:   return bus.rdata[31:0];
      K_RD1:   return bus.rdata[63:32];
      K_RB0:   return 32'(bus.rbusy[0]);
      K_RB1:   return 32'(bus.rbusy[1]);
      default: return 32'(bus.ready);
    endcase
  endfunction

  // let combinational outputs settle, then compare everything queued
  task automatic drain();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.kind), e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen = '0;
    bus.issue_valid = 1'b0;
    bus.clr_req = 1'b0;
  endtask

  task automatic setw(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen[p] = 1'b1;
    bus.waddr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic setr(input int p, input logic [AW-1:0] a);
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.issue_valid = 1'b1;
    bus.issue_rd = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0; bus.issue_rd = '0;
    idle();

    // reset held for two edges
    setr(0, 5'd9);
    cyc();
    push(K_RDY, "rst_ready", 32'd0);
    push(K_RB0, "rst_rbusy0", 32'd0);
    push(K_RD0, "rst_rdata0", 32'd0);
    drain();
    cyc();
    reset = 1'b1;

    n = 0;
    do begin cyc(); n++; end while (!bus.ready && n < 100);
    chk("init_len", 32'(n), 32'd32);

    // preset and cleared entry
    setr(0, 5'd9); setr(1, 5'd5);
    push(K_RD0, "preset_9", 32'd100);
    push(K_RD1, "zero_5", 32'd0);
    push(K_RB0, "run_rbusy0", 32'd0);
    drain();

    // write conflict on addr 7: port 1 wins, visible by bypass then storage
    setw(0, 5'd7, 32'h0000AAAA); setw(1, 5'd7, 32'h00005555); setr(0, 5'd7);
    push(K_RD0, "conflict_bypass", 32'h5555);
    drain();
    cyc(); idle();
    push(K_RD0, "conflict_mem", 32'h5555);
    drain();

    // scoreboard set, then clear by write with bypass masking
    issue(5'd3);
    cyc(); idle(); setr(1, 5'd3);
    push(K_RB1, "busy3_set", 32'd1);
    push(K_RD1, "mem3_old", 32'd0);
    drain();
    cyc(); setw(0, 5'd3, 32'h1234);
    push(K_RB1, "busy3_masked", 32'd0);
    push(K_RD1, "bypass3", 32'h1234);
    drain();
    cyc(); idle();
    push(K_RB1, "busy3_clr", 32'd0);
    push(K_RD1, "mem3", 32'h1234);
    drain();

    // issue and write same entry: set wins
    issue(5'd4); setw(0, 5'd4, 32'h44);
    cyc(); idle(); setr(0, 5'd4);
    push(K_RB0, "busy4_setwins", 32'd1);
    push(K_RD0, "mem4", 32'h44);
    drain();

    // entry 0 is hardwired
    setw(0, 5'd0, 32'hFFFF); issue(5'd0); setr(0, 5'd0); setr(1, 5'd0);
    push(K_RD0, "zero_bypass", 32'd0);
    push(K_RB0, "zero_rbusy_now", 32'd0);
    drain();
    cyc(); idle();
    push(K_RD1, "zero_mem", 32'd0);
    push(K_RB1, "zero_rbusy", 32'd0);
    drain();

    // set up state that re-init must wipe
    setw(1, 5'd12, 32'h77); issue(5'd10);
    cyc(); idle(); setr(0, 5'd12); setr(1, 5'd10);
    push(K_RD0, "mem12", 32'h77);
    push(K_RB1, "busy10_set", 32'd1);
    drain();

    // clr_req with a same-cycle write: bypass still shows it
    setw(0, 5'd12, 32'h99); bus.clr_req = 1'b1;
    push(K_RD0, "clr_bypass", 32'h99);
    drain();
    cyc(); idle();

    // INIT: outputs masked, issue ignored
    issue(5'd5); setr(0, 5'd9);
    push(K_RDY, "init_ready", 32'd0);
    push(K_RD0, "init_rdata", 32'd0);
    push(K_RB1, "init_rbusy", 32'd0);
    drain();
    n = 0;
    do begin cyc(); idle(); n++; end while (!bus.ready && n < 100);
    chk("reinit_len", 32'(n), 32'd32);

    for (int a = 0; a < 32; a++) begin
      setr(1, 5'(a));
      push(K_RB1, $sformatf("post_busy%0d", a), 32'd0);
      push(K_RD1, $sformatf("post_mem%0d", a), (a == 9) ? 32'd100 : 32'd0);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
